// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V core: ALU codes, opcodes,
// controller states and datapath mux encodings.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_LUI = 4'b1000;
  localparam logic [3:0] ALU_ORI = 4'b1001;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_EXEC_LUI = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_WB_ALU   = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_ILLEGAL  = 4'd12
  } state_e;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MEM_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  // States that hold a memory request open until mem_ready is seen.
  function automatic logic is_mem_wait_state(input state_e st);
    return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/riscv_instr_decode.sv
// Combinational instruction classifier: picks the state that follows DECODE
// and the ALU operation used by EXEC_I.
module riscv_instr_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output state_e     next_state,
  output logic [3:0] exec_i_alu_op
);

  // Opcode/funct lookup; anything not recognised lands in ST_ILLEGAL.
  always_comb begin
    next_state    = ST_ILLEGAL;
    exec_i_alu_op = ALU_ADD;
    case (opcode)
      OP_R_TYPE: begin
        if ((funct3 == F3_ADD) && (funct7 == F7_BASE)) next_state = ST_EXEC_R;
        else                                            next_state = ST_ILLEGAL;
      end
      OP_IMM: begin
        if (funct3 == F3_ADD) begin
          next_state    = ST_EXEC_I;
          exec_i_alu_op = ALU_ADD;
        end else if (funct3 == F3_OR) begin
          next_state    = ST_EXEC_I;
          exec_i_alu_op = ALU_ORI;
        end else begin
          next_state    = ST_ILLEGAL;
          exec_i_alu_op = ALU_ADD;
        end
      end
      OP_LUI:    next_state = ST_EXEC_LUI;
      OP_LOAD, OP_STORE: begin
        if (funct3 == F3_WORD) next_state = ST_MEM_ADDR;
        else                   next_state = ST_ILLEGAL;
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) next_state = ST_BRANCH;
        else                  next_state = ST_ILLEGAL;
      end
      default:   next_state = ST_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Moore control FSM for the multicycle RISC-V core with memory-wait timeout.
// Optional performance counters are enabled by defining RISCV_CTRL_PERF_CNT_EN.
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       old_pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [3:0] alu_operation_o,
  output logic       illegal_o,
  output logic       mem_timeout_o,
  output logic [3:0] state_o
`ifdef RISCV_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired_o,
  output logic [31:0] cycles_o
`endif
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX < 32'd2) ? 32'd1 : $clog2(MEM_WAIT_MAX + 32'd1);
  // Timeout fires on the wait cycle that would bring the count up to MEM_WAIT_MAX.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 32'd1);

  state_e           state_r;
  state_e           next_state_s;
  state_e           dec_next_state_s;
  logic [3:0]       dec_alu_op_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             waiting_s;
  logic             timeout_hit_s;
  logic             illegal_r;
  logic             mem_timeout_r;

  riscv_instr_decode u_decode (
    .opcode        (opcode_i),
    .funct3        (funct3_i),
    .funct7        (funct7_i),
    .next_state    (dec_next_state_s),
    .exec_i_alu_op (dec_alu_op_s)
  );

  assign waiting_s     = is_mem_wait_state(state_r) && !mem_ready_i;
  assign timeout_hit_s = waiting_s && (wait_cnt_r == CNT_LAST);

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:     next_state_s = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready_i)        next_state_s = ST_DECODE;
        else if (timeout_hit_s) next_state_s = ST_ILLEGAL;
        else                    next_state_s = ST_FETCH;
      end
      ST_DECODE:   next_state_s = dec_next_state_s;
      ST_EXEC_R,
      ST_EXEC_I,
      ST_EXEC_LUI: next_state_s = ST_WB_ALU;
      ST_MEM_ADDR: begin
        if (opcode_i == OP_STORE) next_state_s = ST_MEM_WR;
        else                      next_state_s = ST_MEM_RD;
      end
      ST_MEM_RD: begin
        if (mem_ready_i)        next_state_s = ST_WB_MEM;
        else if (timeout_hit_s) next_state_s = ST_ILLEGAL;
        else                    next_state_s = ST_MEM_RD;
      end
      ST_MEM_WR: begin
        if (mem_ready_i)        next_state_s = ST_FETCH;
        else if (timeout_hit_s) next_state_s = ST_ILLEGAL;
        else                    next_state_s = ST_MEM_WR;
      end
      ST_WB_ALU,
      ST_WB_MEM,
      ST_BRANCH:   next_state_s = ST_FETCH;
      ST_ILLEGAL:  next_state_s = ST_ILLEGAL;
      default:     next_state_s = ST_ILLEGAL;
    endcase
  end

  // State register, memory-wait counter and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= '0;
      illegal_r     <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      illegal_r     <= illegal_r | (next_state_s == ST_ILLEGAL);
      mem_timeout_r <= mem_timeout_r | timeout_hit_s;
      if (next_state_s != state_r) wait_cnt_r <= '0;
      else if (waiting_s)          wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      else                         wait_cnt_r <= wait_cnt_r;
    end
  end

  // Datapath control decode from the current state.
  always_comb begin
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    i_or_d_o        = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    old_pc_write_o  = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = SRC_A_PC;
    alu_src_b_o     = SRC_B_RS2;
    result_src_o    = RES_ALU_OUT;
    alu_operation_o = ALU_ADD;
    case (state_r)
      ST_FETCH: begin
        mem_read_o     = 1'b1;
        alu_src_b_o    = SRC_B_FOUR;
        ir_write_o     = mem_ready_i;
        pc_write_o     = mem_ready_i;
        old_pc_write_o = mem_ready_i;
      end
      ST_DECODE: begin
        alu_src_a_o = SRC_A_OLD_PC;
        alu_src_b_o = SRC_B_IMM;
      end
      ST_EXEC_R: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_RS2;
      end
      ST_EXEC_I: begin
        alu_src_a_o     = SRC_A_RS1;
        alu_src_b_o     = SRC_B_IMM;
        alu_operation_o = dec_alu_op_s;
      end
      ST_EXEC_LUI: begin
        alu_src_b_o     = SRC_B_IMM;
        alu_operation_o = ALU_LUI;
      end
      ST_MEM_ADDR: begin
        alu_src_a_o = SRC_A_RS1;
        alu_src_b_o = SRC_B_IMM;
      end
      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      ST_WB_ALU: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_ALU_OUT;
      end
      ST_WB_MEM: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_MEM_DATA;
      end
      ST_BRANCH: begin
        alu_src_a_o     = SRC_A_RS1;
        alu_src_b_o     = SRC_B_RS2;
        alu_operation_o = ALU_SUB;
        result_src_o    = RES_ALU_OUT;
        pc_write_o      = zero_i;
      end
      default: begin
        mem_read_o = 1'b0;
      end
    endcase
  end

  assign illegal_o     = illegal_r;
  assign mem_timeout_o = mem_timeout_r;
  assign state_o       = 4'(state_r);

`ifdef RISCV_CTRL_PERF_CNT_EN
  logic [31:0] retired_r;
  logic [31:0] cycles_r;
  logic        retire_s;

  assign retire_s = (next_state_s == ST_FETCH) &&
                    ((state_r == ST_WB_ALU) || (state_r == ST_WB_MEM) ||
                     (state_r == ST_MEM_WR) || (state_r == ST_BRANCH));

  // Retired-instruction and active-cycle counters, free-running modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_r <= 32'd0;
      cycles_r  <= 32'd0;
    end else begin
      if (retire_s) retired_r <= retired_r + 32'd1;
      else          retired_r <= retired_r;
      if ((state_r != ST_IDLE) && (state_r != ST_ILLEGAL)) cycles_r <= cycles_r + 32'd1;
      else                                                 cycles_r <= cycles_r;
    end
  end

  assign retired_o = retired_r;
  assign cycles_o  = cycles_r;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: directed instruction sequences push
// per-cycle expectations; a negedge monitor pops and compares them.
module tb_riscv_multicycle_ctrl;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4, S_LUI = 4'd5,   S_MADDR = 4'd6,  S_MRD = 4'd7;
  localparam logic [3:0] S_MWR = 4'd8,   S_WB_ALU = 4'd9, S_WB_MEM = 4'd10, S_BRANCH = 4'd11;
  localparam logic [3:0] S_ILL = 4'd12;
  localparam logic [3:0] A_ADD = 4'b0000, A_ORI = 4'b1001;

  typedef logic [22:0] vec_t;
  typedef struct {
    int   tag;
    vec_t v;
  } exp_t;

  logic clk = 1'b0;
  logic reset, reset1;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic zero, mem_ready, mem_ready1;

  logic       mr0, mw0, iod0, irw0, pcw0, opw0, rw0, ill0, tmo0;
  logic [1:0] sa0, sb0, rs0;
  logic [3:0] alu0, st0;
  logic       mr1, mw1, iod1, irw1, pcw1, opw1, rw1, ill1, tmo1;
  logic [1:0] sa1, sb1, rs1;
  logic [3:0] alu1, st1;
`ifdef RISCV_CTRL_PERF_CNT_EN
  logic [31:0] ret0, cyc0, ret1, cyc1;
`endif

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.MEM_WAIT_MAX(15)) u_dut (
    .clk(clk), .reset(reset), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .zero_i(zero), .mem_ready_i(mem_ready), .mem_read_o(mr0), .mem_write_o(mw0),
    .i_or_d_o(iod0), .ir_write_o(irw0), .pc_write_o(pcw0), .old_pc_write_o(opw0),
    .reg_write_o(rw0), .alu_src_a_o(sa0), .alu_src_b_o(sb0), .result_src_o(rs0),
    .alu_operation_o(alu0), .illegal_o(ill0), .mem_timeout_o(tmo0), .state_o(st0)
`ifdef RISCV_CTRL_PERF_CNT_EN
    , .retired_o(ret0), .cycles_o(cyc0)
`endif
  );

  riscv_multicycle_ctrl #(.MEM_WAIT_MAX(3)) u_dut_to (
    .clk(clk), .reset(reset1), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .zero_i(zero), .mem_ready_i(mem_ready1), .mem_read_o(mr1), .mem_write_o(mw1),
    .i_or_d_o(iod1), .ir_write_o(irw1), .pc_write_o(pcw1), .old_pc_write_o(opw1),
    .reg_write_o(rw1), .alu_src_a_o(sa1), .alu_src_b_o(sb1), .result_src_o(rs1),
    .alu_operation_o(alu1), .illegal_o(ill1), .mem_timeout_o(tmo1), .state_o(st1)
`ifdef RISCV_CTRL_PERF_CNT_EN
    , .retired_o(ret1), .cycles_o(cyc1)
`endif
  );

  vec_t act0, act1;
  assign act0 = {st0, mr0, mw0, iod0, irw0, pcw0, opw0, rw0, sa0, sb0, rs0, alu0, ill0, tmo0};
  assign act1 = {st1, mr1, mw1, iod1, irw1, pcw1, opw1, rw1, sa1, sb1, rs1, alu1, ill1, tmo1};

  // Expected control word for a state, taken from the state table.
  function automatic vec_t model(input logic [3:0] st, input logic rdy, input logic z,
                                 input logic [3:0] eiop, input logic ill, input logic tmo);
    logic mr, mw, iod, irw, pcw, opw, rw;
    logic [1:0] sa, sb, rs;
    logic [3:0] alu;
    {mr, mw, iod, irw, pcw, opw, rw} = 7'b0000000;
    sa = 2'b00; sb = 2'b00; rs = 2'b00; alu = 4'b0000;
    case (st)
      S_FETCH:    begin mr = 1'b1; sb = 2'b10; irw = rdy; pcw = rdy; opw = rdy; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      S_EXEC_R:   begin sa = 2'b10; sb = 2'b00; end
      S_EXEC_I:   begin sa = 2'b10; sb = 2'b01; alu = eiop; end
      S_LUI:      begin sb = 2'b01; alu = 4'b1000; end
      S_MADDR:    begin sa = 2'b10; sb = 2'b01; end
      S_MRD:      begin mr = 1'b1; iod = 1'b1; end
      S_MWR:      begin mw = 1'b1; iod = 1'b1; end
      S_WB_ALU:   begin rw = 1'b1; end
      S_WB_MEM:   begin rw = 1'b1; rs = 2'b01; end
      S_BRANCH:   begin sa = 2'b10; sb = 2'b00; alu = 4'b0001; pcw = z; end
      default:    begin mr = 1'b0; end
    endcase
    return {st, mr, mw, iod, irw, pcw, opw, rw, sa, sb, rs, alu, ill, tmo};
  endfunction

  function automatic string tag_name(input int t);
    case (t)
      0: return "reset";       1: return "add";         2: return "ori";
      3: return "lui";         4: return "lw_wait";     5: return "ready_wins";
      6: return "sw";          7: return "beq_taken";   8: return "beq_not_taken";
      9: return "reset_mid";   10: return "illegal";    11: return "timeout";
      default: return "unknown";
    endcase
  endfunction

  task automatic set_instr(input logic [31:0] ir);
    opcode = ir[6:0];
    funct3 = ir[14:12];
    funct7 = ir[31:25];
  endtask

  // One cycle of stimulus on instance sel, with its expectation queued.
  task automatic cyc(input bit sel, input logic [3:0] st, input logic rdy, input logic z,
                     input logic [3:0] eiop, input logic ill, input logic tmo, input int tag);
    exp_t e;
    if (sel) mem_ready1 = rdy;
    else     mem_ready  = rdy;
    zero  = z;
    e.tag = tag;
    e.v   = model(st, rdy, z, eiop, ill, tmo);
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic c0(input logic [3:0] st, input logic rdy, input int tag);
    cyc(1'b0, st, rdy, 1'b0, A_ADD, 1'b0, 1'b0, tag);
  endtask

  // Monitor: the controller presents a new control word every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      n_checks++;
      if (act0 !== e.v) begin
        n_fails++;
        $display("FAIL %s (dut0): state_o=%0d got=%h expected=%h", tag_name(e.tag), st0, act0, e.v);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      n_checks++;
      if (act1 !== e.v) begin
        n_fails++;
        $display("FAIL %s (dut_to): state_o=%0d got=%h expected=%h", tag_name(e.tag), st1, act1, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset1 = 1'b1; zero = 1'b0; mem_ready = 1'b0; mem_ready1 = 1'b0;
    set_instr(32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    c0(S_IDLE, 1'b1, 0);
    reset = 1'b0;
    c0(S_IDLE, 1'b1, 0);

    // add x3,x1,x2
    set_instr(32'h0020_81B3);
    c0(S_FETCH, 1'b1, 1); c0(S_DECODE, 1'b1, 1); c0(S_EXEC_R, 1'b1, 1); c0(S_WB_ALU, 1'b1, 1);

    // ori x1,x0,5
    set_instr(32'h0050_6093);
    c0(S_FETCH, 1'b1, 2); c0(S_DECODE, 1'b1, 2);
    cyc(1'b0, S_EXEC_I, 1'b1, 1'b0, A_ORI, 1'b0, 1'b0, 2);
    c0(S_WB_ALU, 1'b1, 2);

    // lui x1,0x12345
    set_instr(32'h1234_50B7);
    c0(S_FETCH, 1'b1, 3); c0(S_DECODE, 1'b1, 3); c0(S_LUI, 1'b1, 3); c0(S_WB_ALU, 1'b1, 3);

    // lw x1,0(x2) with three wait cycles
    set_instr(32'h0001_2083);
    c0(S_FETCH, 1'b1, 4); c0(S_DECODE, 1'b0, 4); c0(S_MADDR, 1'b0, 4);
    for (int i = 0; i < 3; i++) c0(S_MRD, 1'b0, 4);
    c0(S_MRD, 1'b1, 4); c0(S_WB_MEM, 1'b0, 4);

    // addi: 14 fetch waits, then ready on the cycle the count would hit 15
    set_instr(32'h0050_0093);
    for (int i = 0; i < 14; i++) c0(S_FETCH, 1'b0, 5);
    c0(S_FETCH, 1'b1, 5); c0(S_DECODE, 1'b0, 5);
    cyc(1'b0, S_EXEC_I, 1'b0, 1'b0, A_ADD, 1'b0, 1'b0, 5);
    c0(S_WB_ALU, 1'b0, 5);

    // sw x1,0(x2) with one write wait
    set_instr(32'h0011_2023);
    c0(S_FETCH, 1'b1, 6); c0(S_DECODE, 1'b1, 6); c0(S_MADDR, 1'b1, 6);
    c0(S_MWR, 1'b0, 6); c0(S_MWR, 1'b1, 6);

    // beq taken, then not taken
    set_instr(32'h0020_8463);
    c0(S_FETCH, 1'b1, 7); c0(S_DECODE, 1'b1, 7);
    cyc(1'b0, S_BRANCH, 1'b1, 1'b1, A_ADD, 1'b0, 1'b0, 7);
    c0(S_FETCH, 1'b1, 8); c0(S_DECODE, 1'b1, 8);
    cyc(1'b0, S_BRANCH, 1'b1, 1'b0, A_ADD, 1'b0, 1'b0, 8);

    // lw aborted by reset while the read is pending
    set_instr(32'h0001_2083);
    c0(S_FETCH, 1'b1, 9); c0(S_DECODE, 1'b1, 9); c0(S_MADDR, 1'b1, 9); c0(S_MRD, 1'b0, 9);
    #1;
    reset = 1'b1;
    c0(S_IDLE, 1'b1, 9); c0(S_IDLE, 1'b1, 9);
    reset = 1'b0;
    c0(S_IDLE, 1'b1, 9);
    set_instr(32'h0000_007F);
    c0(S_FETCH, 1'b1, 9);

    // opcode 0x7F -> ILLEGAL, inert for 20 cycles whatever ready does
    c0(S_DECODE, 1'b1, 10);
    for (int i = 0; i < 20; i++) cyc(1'b0, S_ILL, i[0], 1'b1, A_ADD, 1'b1, 1'b0, 10);

    // MEM_WAIT_MAX=3 instance: fetch never acknowledged
    reset1 = 1'b0;
    cyc(1'b1, S_IDLE, 1'b0, 1'b0, A_ADD, 1'b0, 1'b0, 11);
    for (int i = 0; i < 3; i++) cyc(1'b1, S_FETCH, 1'b0, 1'b0, A_ADD, 1'b0, 1'b0, 11);
    for (int i = 0; i < 3; i++) cyc(1'b1, S_ILL, 1'b0, 1'b0, A_ADD, 1'b1, 1'b1, 11);

    repeat (2) @(posedge clk);
    n_checks++;
    if ((q0.size() != 0) || (q1.size() != 0)) begin
      n_fails++;
      $display("FAIL drain: pending expectations dut0=%0d dut_to=%0d required 0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Moore-style control FSM for the multicycle RISC-V core. It sequences fetch, decode, execute, memory and writeback over several cycles and drives the 4-bit ALU operation code and operand selects. It consumes the ALU `Zero` flag and a shared instruction/data memory ready handshake. It sits between the instruction register and the datapath muxes, register file, PC and memory.

## Interface
- Parameters:
- `MEM_WAIT_MAX`, default 15: maximum cycles to wait for `mem_ready_i` before raising `mem_timeout_o`.
- Ports:
- `clk` in 1: core clock; rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `opcode_i` in 7: IR[6:0].
- `funct3_i` in 3: IR[14:12].
- `funct7_i` in 7: IR[31:25].
- `zero_i` in 1: ALU zero flag, valid in the cycle it is produced.
- `mem_ready_i` in 1: memory accepted the write / read data valid.
- `mem_read_o` out 1: memory read strobe, held until ready.
- `mem_write_o` out 1: memory write strobe, held until ready.
- `i_or_d_o` out 1: 0 = PC address, 1 = ALUOut address.
- `ir_write_o` out 1: load the instruction register.
- `pc_write_o` out 1: load the PC (unconditional update).
- `old_pc_write_o` out 1: latch the current PC as OldPC.
- `reg_write_o` out 1: register-file write enable.
- `alu_src_a_o` out 2: 00 PC, 01 OldPC, 10 rs1.
- `alu_src_b_o` out 2: 00 rs2, 01 imm, 10 constant 4.
- `result_src_o` out 2: 00 ALUOut, 01 memory data, 10 ALU result.
- `alu_operation_o` out 4: ALU opcode.
- `illegal_o` out 1: sticky illegal-instruction flag.
- `mem_timeout_o` out 1: sticky timeout flag.
- `state_o` out 4: current state, for debug.

## Operation
- ALU codes:
  - ADD is 0000.
  - SUB is 0001; the ALU gains SUB as part of this work.
  - LUI is 1000.
  - ORI is 1001.
  - ALU_Operation is ADD in every state not listed below.
- Supported instructions:
  - add: opcode 0110011, f3 000, f7 0000000.
  - addi: opcode 0010011, f3 000.
  - ori: opcode 0010011, f3 110.
  - lui: opcode 0110111.
  - lw: opcode 0000011, f3 010.
  - sw: opcode 0100011, f3 010.
  - beq: opcode 1100011, f3 000.
  - Anything else goes to ILLEGAL.
- States and transitions:
  - IDLE: all outputs 0. Goes to FETCH on the next clock.
  - FETCH: mem_read=1, i_or_d=0, srcA=PC, srcB=4, ADD. Stays while !mem_ready_i. On ready it pulses ir_write, pc_write and old_pc_write, then goes to DECODE.
  - DECODE: srcA=OldPC, srcB=imm, ADD; ALUOut receives the branch target. The next state is chosen by opcode/funct:
    - add goes to EXEC_R.
    - addi/ori go to EXEC_I.
    - lui goes to EXEC_LUI.
    - lw/sw go to MEM_ADDR.
    - beq goes to BRANCH.
    - illegal goes to ILLEGAL.
  - EXEC_R: srcA=rs1, srcB=rs2, ADD. Goes to WB_ALU.
  - EXEC_I: srcA=rs1, srcB=imm, ADD (f3 000) or ORI (f3 110). Goes to WB_ALU.
  - EXEC_LUI: srcB=imm, LUI. Goes to WB_ALU.
  - MEM_ADDR: srcA=rs1, srcB=imm, ADD. Goes to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: mem_read=1, i_or_d=1. Waits for ready, then goes to WB_MEM.
  - MEM_WR: mem_write=1, i_or_d=1. Waits for ready, then goes to FETCH.
  - WB_ALU: reg_write=1, result_src=00. Goes to FETCH.
  - WB_MEM: reg_write=1, result_src=01. Goes to FETCH.
  - BRANCH: srcA=rs1, srcB=rs2, SUB, result_src=00. pc_write=zero_i. Goes to FETCH.
  - ILLEGAL: all strobes 0 and illegal_o=1. Exits only on reset.
- Memory wait timeout:
  - The wait counter increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready_i low.
  - The counter clears on state exit.
  - When the count reaches MEM_WAIT_MAX, mem_timeout_o sets and the FSM goes to ILLEGAL.

## Timing
- State, wait counter and sticky flags are registered. All other outputs decode combinationally from state plus `zero_i`, `mem_ready_i` and opcode.
- Reset values:
  - state = IDLE; every output is 0; counter = 0; flags = 0.
  - Reset asserted mid-instruction aborts at once. No strobe is issued after reset asserts.
- Latency with zero-wait memory (mem_ready_i=1 in the first request cycle), counted from FETCH entry:
  - add/addi/ori/lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - Each memory wait cycle adds 1.
- mem_ready_i is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored elsewhere. mem_read_o/mem_write_o stay stable until the cycle ready is seen.
- pc_write_o, ir_write_o and old_pc_write_o each last exactly one cycle per fetch.
- mem_ready_i in the same cycle the counter hits MEM_WAIT_MAX: ready wins and there is no timeout.

## Configuration
- `RISCV_CTRL_PERF_CNT_EN`:
- Defined: adds the outputs `retired_o` [31:0] and `cycles_o` [31:0].
  - `retired_o` increments on every transition into FETCH from WB_ALU, WB_MEM, MEM_WR or BRANCH.
  - `cycles_o` increments every cycle except in IDLE and ILLEGAL.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: neither port exists and there is no counter logic.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU op constants (ADD, SUB, LUI, ORI).
  - Opcode constants.
  - The state enum.
  - The src-A, src-B and result-src mux encodings.
- The package is also imported by the ALU and the datapath.
- One sub-module, `riscv_instr_decode`: combinational; maps opcode/f3/f7 to the DECODE next state plus the ALU op for EXEC_I.

## Test plan
- Reset asserted in MEM_RD with mem_read_o=1 -> in the same cycle all outputs are 0 and state_o is IDLE; after release, FETCH follows in 2 cycles.
- add x3,x1,x2 (0x002081B3), ready always 1 -> the 4 states are FETCH, DECODE, EXEC_R, WB_ALU; alu_operation_o=0000 in EXEC_R; reg_write_o=1 in WB_ALU only.
- ori (opcode 0010011, f3 110) then lui (0x123450B7) -> alu_operation_o is 1001 in EXEC_I and 1000 in EXEC_LUI.
- lw with mem_ready_i low for 3 cycles in MEM_RD -> mem_read_o=1 and i_or_d_o=1 held for 4 cycles; 8 cycles total; result_src_o=01 in WB_MEM.
- beq with zero_i=1, then beq with zero_i=0 -> pc_write_o is 1 in BRANCH for the first only; alu_operation_o=0001 in both.
- Opcode 0x7F -> ILLEGAL, illegal_o=1, no strobes for 20 cycles. Separately, MEM_WAIT_MAX=3 with ready never asserted in FETCH -> mem_timeout_o=1 after 3 wait cycles.
